// File: rtl/mul_int_seq.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned per operation.
// Full 2*WIDTH-bit product plus its low half, valid/ready on both sides.
module mul_int_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic [WIDTH-1:0]   P_LO
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [2*WIDTH:0] acc;
  logic             neg_en;
  logic             sgn_x;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_nx;
  logic [2*WIDTH-1:0] prod;

  // -2^(W-1) negates to itself, which read unsigned is its magnitude
  assign mag_a  = (is_signed & A[WIDTH-1]) ? -A : A;
  assign mag_b  = (is_signed & B[WIDTH-1]) ? -B : B;
  assign sum    = acc[2*WIDTH:WIDTH] + (mplr[0] ? {1'b0, mcand} : '0);
  assign acc_nx = {sum, acc[WIDTH-1:0]} >> 1;
  assign prod   = acc[2*WIDTH-1:0];

  assign in_ready = (state == IDLE);
  assign P_LO     = P[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      neg_en    <= 1'b0;
      sgn_x     <= 1'b0;
      out_valid <= 1'b0;
      P         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            neg_en <= is_signed;
            sgn_x  <= A[WIDTH-1] ^ B[WIDTH-1];
            mcand  <= mag_a;
            mplr   <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc  <= acc_nx;
          mplr <= mplr >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          P         <= (neg_en & sgn_x) ? -prod : prod;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_int_seq.sv
// Directed bench for mul_int_seq at WIDTH=8 and WIDTH=16.
// Handshake timing, backpressure, async reset and a back-to-back model run.
module tb_mul_int_seq;

  logic clk;
  logic rst;

  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8, plo8;
  logic [15:0] p8;

  logic        iv16, ir16, s16, ov16, or16;
  logic [15:0] a16, b16, plo16;
  logic [31:0] p16;

  int n_chk;
  int n_err;

  mul_int_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .is_signed(s8),
    .out_valid(ov8), .out_ready(or8),
    .P(p8), .P_LO(plo8)
  );

  mul_int_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .A(a16), .B(b16), .is_signed(s16),
    .out_valid(ov16), .out_ready(or16),
    .P(p16), .P_LO(plo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  // Accepts one op, then waits until out_valid is seen.
  // Edge counted is the first edge at which out_valid is already high.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s);
    int n;
    @(negedge clk);
    chk("in_ready_idle", 32'(ir8), 32'd1);
    a8  = a;
    b8  = b;
    s8  = s;
    iv8 = 1'b1;
    @(posedge clk);
    #1;
    a8 = ~a;
    b8 = ~b;
    s8 = ~s;
    chk("in_ready_busy", 32'(ir8), 32'd0);
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    iv8 = 1'b0;
    chk("latency_edge", 32'(n + 1), 32'd10);
  endtask

  task automatic ack8();
    or8 = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_out_valid", 32'(ov8), 32'd0);
    chk("ack_in_ready", 32'(ir8), 32'd1);
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] q[$];
    int got;
    int last;
    int bad;

    n_chk = 0;
    n_err = 0;
    rst  = 1'b1;
    iv8  = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; or16 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir8), 32'd1);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_p", 32'(p8), 32'h0);
    chk("rst_p_lo", 32'(plo8), 32'h0);
    chk("rst_in_ready16", 32'(ir16), 32'd1);
    chk("rst_p16", p16, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run8(8'd255, 8'd255, 1'b0);
    chk("u_ff_ff_p", 32'(p8), 32'hFE01);
    chk("u_ff_ff_lo", 32'(plo8), 32'h01);
    ack8();

    run8(8'hFD, 8'd5, 1'b1);
    chk("s_m3_5_p", 32'(p8), 32'hFFF1);
    chk("s_m3_5_lo", 32'(plo8), 32'hF1);
    ack8();

    run8(8'hFD, 8'd5, 1'b0);
    chk("u_253_5_p", 32'(p8), 32'h04F1);
    chk("u_253_5_lo", 32'(plo8), 32'hF1);
    ack8();

    run8(8'h80, 8'h80, 1'b1);
    chk("s_min_min_p", 32'(p8), 32'h4000);
    ack8();

    run8(8'h80, 8'h7F, 1'b1);
    chk("s_min_max_p", 32'(p8), 32'hC080);
    ack8();

    run8(8'h00, 8'hFF, 1'b1);
    chk("s_zero_p", 32'(p8), 32'h0000);
    ack8();

    // Backpressure
    or8 = 1'b0;
    run8(8'd12, 8'd10, 1'b0);
    chk("bp_p", 32'(p8), 32'h0078);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (p8 !== 16'h0078 || ir8 !== 1'b0 || ov8 !== 1'b1) bad++;
    end
    chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
    ack8();
    chk("bp_p_after_ack", 32'(p8), 32'h0078);

    // Async reset three iterations into BUSY
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(ir8), 32'd1);
    chk("mid_rst_out_valid", 32'(ov8), 32'd0);
    chk("mid_rst_p", 32'(p8), 32'h0);
    chk("mid_rst_p_lo", 32'(plo8), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run8(8'd7, 8'd6, 1'b0);
    chk("post_rst_p", 32'(p8), 32'h002A);
    ack8();

    // Back-to-back at WIDTH=16, in_valid held high throughout
    got  = 0;
    last = 0;
    iv16 = 1'b1;
    a16  = 16'h8000; b16 = 16'h8000; s16 = 1'b1;
    for (int cyc = 0; cyc < 3000 && got < 30; cyc++) begin
      @(negedge clk);
      if (ov16) begin
        if (q.size() == 0) begin
          chk("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("b2b_p", p16, e);
          chk("b2b_p_lo", 32'(plo16), 32'(e[15:0]));
          if (got > 0) chk("b2b_period", 32'(cyc - last), 32'd19);
        end
        last = cyc;
        got++;
      end
      if (ir16) q.push_back(model16(a16, b16, s16));
      @(posedge clk);
      #1;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      s16 = 1'($urandom);
    end
    iv16 = 1'b0;
    chk("b2b_results", 32'(got), 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
